// File: rtl/fp32_pkg.sv
// Shared single-precision encoding helpers for the FP add/sub pipelines:
// field widths, special constants, operand classification and unpacking.
package fp32_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;
    localparam int EXP_INF  = 2 * EXP_BIAS + 1;
    localparam int SUM_W    = MAN_W + 4;   // hidden bit + mantissa + guard/round/sticky

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ZERO,
        DENORM,
        NORMAL,
        INF,
        NAN
    } fp_class_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   man;
        fp_class_t        cls;
    } fp_unpacked_t;

    // Special-case result decided at unpack time and carried down the pipe.
    typedef struct packed {
        logic        en;
        logic        inv;
        logic        neg_zero;
        logic [31:0] val;
    } fp_special_t;

    // Denormals and zeros get exponent 1 with hidden bit 0 so alignment
    // needs no special case; flush turns denormals into signed zeros.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] v, input logic flush);
        fp_unpacked_t u;
        u.sign = v[31];
        u.exp  = v[30:23];
        u.man  = {1'b1, v[MAN_W-1:0]};
        u.cls  = NORMAL;
        if (v[30:23] == '0) begin
            u.exp = 8'd1;
            if (v[MAN_W-1:0] == '0 || flush) begin
                u.cls = ZERO;
                u.man = '0;
            end else begin
                u.cls = DENORM;
                u.man = {1'b0, v[MAN_W-1:0]};
            end
        end else if (v[30:23] == '1) begin
            u.cls = (v[MAN_W-1:0] == '0) ? INF : NAN;
        end
        return u;
    endfunction

endpackage

// File: rtl/fp_lzc27.sv
// Combinational leading-zero counter for the 27-bit normalize path.
// An all-zero input reports 27.
module fp_lzc27 (
    input  logic [26:0] value,
    output logic [4:0]  count
);

    always_comb begin
        count = 5'd27;
        // Ascending scan: the highest set bit is the last to write.
        for (int i = 0; i < 27; i++) begin
            if (value[i]) count = 5'(26 - i);
        end
    end

endmodule

// File: rtl/fp_sub_pipe.sv
// Four-stage pipelined IEEE-754 single subtractor, diff = a - b, round-to-nearest-even.
// Define FP_SUB_DENORM_EN for gradual underflow; otherwise denormals flush to zero.
module fp_sub_pipe
    import fp32_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] diff,
    output logic        flag_invalid,
    output logic        flag_overflow,
    output logic        flag_underflow
);

`ifdef FP_SUB_DENORM_EN
    localparam logic FLUSH = 1'b0;
`else
    localparam logic FLUSH = 1'b1;
`endif

    // Only the valid chain is reset; payload registers run free.
    logic [LATENCY:1] vld_pipe;

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[LATENCY-1:1], in_valid};
    end

    // ---------------- S1: unpack, classify, swap ----------------
    fp_unpacked_t ua, ub, x1, y1;
    fp_special_t  sp1;

    always_comb begin
        ua      = fp_unpack(a, FLUSH);
        ub      = fp_unpack(b, FLUSH);
        ub.sign = ~b[31];
        if ({ua.exp, ua.man} >= {ub.exp, ub.man}) begin
            x1 = ua;
            y1 = ub;
        end else begin
            x1 = ub;
            y1 = ua;
        end

        sp1          = '0;
        sp1.neg_zero = (ua.cls == ZERO) && (ub.cls == ZERO) && ua.sign && ub.sign;
        if (ua.cls == NAN || ub.cls == NAN) begin
            sp1.en  = 1'b1;
            sp1.inv = 1'b1;
            sp1.val = QNAN;
        end else if (ua.cls == INF && ub.cls == INF && a[31] == b[31]) begin
            sp1.en  = 1'b1;
            sp1.inv = 1'b1;
            sp1.val = QNAN;
        end else if (ua.cls == INF) begin
            sp1.en  = 1'b1;
            sp1.val = {ua.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (ub.cls == INF) begin
            sp1.en  = 1'b1;
            sp1.val = {ub.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    fp_unpacked_t     s1_x, s1_y;
    logic [EXP_W-1:0] s1_ediff;
    fp_special_t      s1_sp;

    always_ff @(posedge clk) begin
        s1_x     <= x1;
        s1_y     <= y1;
        s1_ediff <= x1.exp - y1.exp;
        s1_sp    <= sp1;
    end

    // ---------------- S2: align smaller operand ----------------
    logic [4:0]           sh2;
    logic [SUM_W+MAN_W:0] ext2;
    logic [SUM_W-1:0]     ym2;

    // Beyond 26 places the smaller operand only survives as sticky.
    assign sh2  = (s1_ediff > 8'd26) ? 5'd26 : s1_ediff[4:0];
    assign ext2 = {s1_y.man, 26'd0} >> sh2;
    assign ym2  = {ext2[49:24], |ext2[23:0]};

    logic [SUM_W-1:0] s2_xm, s2_ym;
    logic             s2_sign, s2_sub;
    logic [EXP_W-1:0] s2_exp;
    fp_special_t      s2_sp;

    always_ff @(posedge clk) begin
        s2_xm   <= {s1_x.man, 3'b000};
        s2_ym   <= ym2;
        s2_sign <= s1_x.sign;
        s2_sub  <= s1_x.sign ^ s1_y.sign;
        s2_exp  <= s1_x.exp;
        s2_sp   <= s1_sp;
    end

    // ---------------- S3: magnitude add/subtract ----------------
    logic [SUM_W:0]   s3_sum;
    logic             s3_sign;
    logic [EXP_W-1:0] s3_exp;
    fp_special_t      s3_sp;

    always_ff @(posedge clk) begin
        s3_sum  <= s2_sub ? ({1'b0, s2_xm} - {1'b0, s2_ym})
                          : ({1'b0, s2_xm} + {1'b0, s2_ym});
        s3_sign <= s2_sign;
        s3_exp  <= s2_exp;
        s3_sp   <= s2_sp;
    end

    // ---------------- S4: normalize, round, pack ----------------
    logic [4:0]       lz;
    logic [4:0]       shamt;
    logic [SUM_W-1:0] m;
    logic [9:0]       e, ef;
    logic             rnd;
    logic [MAN_W+1:0] mr;
    logic [31:0]      res;
    logic             inv4, ovf4, unf4;
`ifdef FP_SUB_DENORM_EN
    logic [EXP_W-1:0] lim;
`endif

    fp_lzc27 u_lzc (
        .value (s3_sum[SUM_W-1:0]),
        .count (lz)
    );

    always_comb begin
        shamt = lz;
`ifdef FP_SUB_DENORM_EN
        // Stop shifting at exponent 1; what remains unnormalized is a denormal.
        lim = s3_exp - 8'd1;
        if ({3'b000, lz} > lim) shamt = lim[4:0];
`endif
        if (s3_sum[SUM_W]) begin
            m = {s3_sum[SUM_W:2], s3_sum[1] | s3_sum[0]};
            e = {2'b00, s3_exp} + 10'd1;
        end else begin
            m = s3_sum[SUM_W-1:0] << shamt;
            e = {2'b00, s3_exp} - {5'd0, shamt};
        end

        rnd = m[2] & (m[1] | m[0] | m[3]);
        mr  = {1'b0, m[SUM_W-1:3]} + {{MAN_W+1{1'b0}}, rnd};
        if (mr[MAN_W+1])    ef = e + 10'd1;
        else if (mr[MAN_W]) ef = e;
        else                ef = '0;

        res  = {s3_sign, ef[EXP_W-1:0], mr[MAN_W-1:0]};
        inv4 = 1'b0;
        ovf4 = 1'b0;
        unf4 = 1'b0;
        if (s3_sp.en) begin
            res  = s3_sp.val;
            inv4 = s3_sp.inv;
        end else if (s3_sum == '0) begin
            res = {s3_sp.neg_zero, 31'd0};
        end else if (!ef[9] && ef >= 10'(EXP_INF)) begin
            res  = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf4 = 1'b1;
        end
`ifdef FP_SUB_DENORM_EN
        else begin
            unf4 = ~m[SUM_W-1] & (|m[2:0]);
        end
`else
        else if (ef[9] || ef == 10'd0) begin
            res  = {s3_sign, 31'd0};
            unf4 = 1'b1;
        end
`endif
    end

    logic [31:0] diff_q;
    logic        inv_q, ovf_q, unf_q;

    always_ff @(posedge clk) begin
        diff_q <= res;
        inv_q  <= inv4;
        ovf_q  <= ovf4;
        unf_q  <= unf4;
    end

    // Payload is unreset, so outputs are masked to zero outside valid slots.
    assign out_valid      = vld_pipe[LATENCY];
    assign diff           = out_valid ? diff_q : '0;
    assign flag_invalid   = out_valid & inv_q;
    assign flag_overflow  = out_valid & ovf_q;
    assign flag_underflow = out_valid & unf_q;

endmodule

// File: tb/tb_fp_sub_pipe.sv
// Scoreboard bench for fp_sub_pipe: directed operand pairs with hand-computed
// results, checked in order and at exact latency by an independent monitor.
module tb_fp_sub_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic [31:0] diff;
    logic        flag_invalid, flag_overflow, flag_underflow;

    fp_sub_pipe dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .a              (a),
        .b              (b),
        .out_valid      (out_valid),
        .diff           (diff),
        .flag_invalid   (flag_invalid),
        .flag_overflow  (flag_overflow),
        .flag_underflow (flag_underflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        logic        inv, ovf, unf;
        int          due;
        int          id;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   nchk = 0;
    int   nerr = 0;
    int   nid  = 0;

    localparam int LAT = 4;

`ifdef FP_SUB_DENORM_EN
    localparam logic [31:0] DEN_EXP = 32'h007F_FFFF;
`else
    localparam logic [31:0] DEN_EXP = 32'h0080_0000;
`endif

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] ed,
                         input logic ei, input logic eo, input logic eu);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        e.d   = ed;
        e.inv = ei;
        e.ovf = eo;
        e.unf = eu;
        e.due = cyc + LAT;
        e.id  = nid;
        nid++;
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic check_quiet(input string name);
        nchk++;
        if (out_valid !== 1'b0 || diff !== 32'h0 || flag_invalid !== 1'b0 ||
            flag_overflow !== 1'b0 || flag_underflow !== 1'b0) begin
            nerr++;
            $display("FAIL %s: got vld=%b diff=%h inv=%b ovf=%b unf=%b, want all zero",
                     name, out_valid, diff, flag_invalid, flag_overflow, flag_underflow);
        end
    endtask

    // Monitor: every valid output must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1) begin
            nchk++;
            if (sbq.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_out: got diff=%h at cyc %0d, want no output", diff, cyc);
            end else begin
                mon_e = sbq.pop_front();
                if (diff !== mon_e.d || flag_invalid !== mon_e.inv || flag_overflow !== mon_e.ovf ||
                    flag_underflow !== mon_e.unf || cyc != mon_e.due) begin
                    nerr++;
                    $display("FAIL vec%0d: got diff=%h inv=%b ovf=%b unf=%b cyc=%0d, want diff=%h inv=%b ovf=%b unf=%b cyc=%0d",
                             mon_e.id, diff, flag_invalid, flag_overflow, flag_underflow, cyc,
                             mon_e.d, mon_e.inv, mon_e.ovf, mon_e.unf, mon_e.due);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset_state");
        rst = 1'b0;

        // Normal subtraction: 10000 - 8000 = 2000
        issue(32'h461C4000, 32'h45FA0000, 32'h44FA0000, 0, 0, 0);
        idle(6);

        // Cancellation followed by 8 back-to-back pairs
        issue(32'h45FA0000, 32'h45FA0000, 32'h00000000, 0, 0, 0);
        issue(32'h40000000, 32'h3F800000, 32'h3F800000, 0, 0, 0); // 2 - 1
        issue(32'h40400000, 32'h40000000, 32'h3F800000, 0, 0, 0); // 3 - 2
        issue(32'h3F800000, 32'h40000000, 32'hBF800000, 0, 0, 0); // 1 - 2
        issue(32'h3F800000, 32'hBF800000, 32'h40000000, 0, 0, 0); // 1 - (-1)
        issue(32'h00000000, 32'h3F800000, 32'hBF800000, 0, 0, 0); // 0 - 1
        issue(32'h80000000, 32'h00000000, 32'h80000000, 0, 0, 0); // -0 - +0
        issue(32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 0, 0, 0); // 1 - 2^-24, exact
        issue(32'h3F800000, 32'h33000000, 32'h3F800000, 0, 0, 0); // 1 - 2^-25, tie to even
        idle(6);

        // Specials, overflow, denormal
        issue(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1, 0, 0);
        issue(32'h7F800001, 32'h45FA0000, 32'h7FC00000, 1, 0, 0);
        issue(32'h7F800000, 32'h3F800000, 32'h7F800000, 0, 0, 0);
        issue(32'h3F800000, 32'h7F800000, 32'hFF800000, 0, 0, 0);
        issue(32'h7F800000, 32'hFF800000, 32'h7F800000, 0, 0, 0);
        issue(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 0, 1, 0);
        issue(32'h00800000, 32'h00000001, DEN_EXP,      0, 0, 0);
        idle(6);

        // Reset mid-flight: three pairs in flight are dropped
        issue(32'h461C4000, 32'h45FA0000, 32'h44FA0000, 0, 0, 0);
        issue(32'h40000000, 32'h3F800000, 32'h3F800000, 0, 0, 0);
        issue(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1, 0, 0);
        @(posedge clk);
        #1;
        sbq.delete();
        rst      = 1'b1;
        in_valid = 1'b1;          // sampled with rst: must be discarded
        a        = 32'h3F800000;
        b        = 32'h3F800000;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_quiet($sformatf("post_reset_quiet%0d", i));
        end

        // Recovery after reset
        issue(32'h461C4000, 32'h45FA0000, 32'h44FA0000, 0, 0, 0);
        idle(1);

        for (int i = 0; i < 20 && sbq.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sbq.size() != 0) begin
            nchk++;
            nerr++;
            $display("FAIL drain_timeout: got %0d results pending, want 0", sbq.size());
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
